lockin_demod: RTL

LOCKIN_DEMOD -- requirements
Module: lockin_demod

---
 rtl/lockin_pkg.sv | 16 +
 rtl/lockin_mac.sv | 47 ++++
 rtl/lockin_demod.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lockin_pkg.sv
// Shared types and default widths for the lock-in demodulator.
package lockin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam int DEF_NCH  = 2;
    localparam int DEF_DW   = 16;
    localparam int DEF_RW   = 16;
    localparam int DEF_ACCW = 40;
    localparam int DEF_DECW = 16;

endpackage

// File: rtl/lockin_mac.sv
// Registered signed multiplier feeding a single accumulate adder.
// LOCKIN_OVF_SAT_EN selects saturating adds with a clip indication; otherwise the add wraps.
module lockin_mac
    import lockin_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int RW   = DEF_RW,
    parameter int ACCW = DEF_ACCW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [DW-1:0]   a,
    input  logic signed [RW-1:0]   b,
    input  logic signed [ACCW-1:0] acc_in,
`ifdef LOCKIN_OVF_SAT_EN
    output logic                   clip,
`endif
    output logic signed [ACCW-1:0] acc_out
);

    logic signed [DW+RW-1:0] prod_reg;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg <= '0;
        end else begin
            prod_reg <= a * b;
        end
    end

    assign prod_ext = ACCW'(prod_reg);
    assign sum      = acc_in + prod_ext;

`ifdef LOCKIN_OVF_SAT_EN
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    // Overflow only when both operands share a sign and the sum's sign flips.
    assign clip    = (acc_in[ACCW-1] == prod_ext[ACCW-1]) && (sum[ACCW-1] != acc_in[ACCW-1]);
    assign acc_out = clip ? (acc_in[ACCW-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign acc_out = sum;
`endif

endmodule

// File: rtl/lockin_demod.sv
// Multi-channel lock-in demodulator: time-shared I/Q MAC, decimating accumulators, output buffer.
// Build option LOCKIN_OVF_SAT_EN enables saturating accumulators and the sticky ovf flag.
module lockin_demod
    import lockin_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int DW   = DEF_DW,
    parameter int RW   = DEF_RW,
    parameter int ACCW = DEF_ACCW,
    parameter int DECW = DEF_DECW,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*DW-1:0]      in_sample,
    input  logic signed [RW-1:0]   ref_sin,
    input  logic signed [RW-1:0]   ref_cos,
    input  logic [DECW-1:0]        dec_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHW-1:0]         out_ch,
    output logic signed [ACCW-1:0] out_i,
    output logic signed [ACCW-1:0] out_q,
    output logic                   ovf
);

    localparam int NACC = 2 * NCH;
    localparam int STW  = $clog2(NACC + 2);

    state_t                 state_reg, state_next;
    logic [STW-1:0]         step_reg;
    logic [NCH*DW-1:0]      samp_reg;
    logic signed [RW-1:0]   sin_reg, cos_reg;
    logic [DECW-1:0]        len_reg, cnt_reg;
    logic [CHW-1:0]         ch_reg;
    logic signed [ACCW-1:0] acc_reg [NACC];
    logic signed [ACCW-1:0] buf_i [NCH];
    logic signed [ACCW-1:0] buf_q [NCH];

    logic signed [DW-1:0]   samp_ch [NCH];
    logic signed [DW-1:0]   mac_a;
    logic signed [RW-1:0]   mac_b;
    logic signed [ACCW-1:0] acc_cur, acc_sum;
    logic                   acc_en, last_step, window_done;
    logic [DECW:0]          cnt_inc;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_split
        assign samp_ch[gi] = samp_reg[gi*DW +: DW];
    end

    // Step k issues accumulator k's product; step k+1 adds it; step NACC+1 closes the sample.
    always_comb begin
        mac_a   = '0;
        mac_b   = '0;
        acc_cur = '0;
        for (int k = 0; k < NACC; k++) begin
            if (state_reg == MAC && step_reg == STW'(k)) begin
                mac_a = samp_ch[k/2];
                mac_b = (k % 2 == 0) ? cos_reg : sin_reg;
            end
            if (step_reg == STW'(k + 1)) begin
                acc_cur = acc_reg[k];
            end
        end
    end

    assign acc_en      = (state_reg == MAC) && (step_reg != '0) && (step_reg <= STW'(NACC));
    assign last_step   = (step_reg == STW'(NACC + 1));
    assign cnt_inc     = {1'b0, cnt_reg} + 1'b1;
    assign window_done = (cnt_inc >= {1'b0, len_reg});

`ifdef LOCKIN_OVF_SAT_EN
    logic mac_clip;
    logic ovf_reg;

    lockin_mac #(.DW(DW), .RW(RW), .ACCW(ACCW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .a       (mac_a),
        .b       (mac_b),
        .acc_in  (acc_cur),
        .clip    (mac_clip),
        .acc_out (acc_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (acc_en && mac_clip) begin
            ovf_reg <= 1'b1;
        end
    end
    assign ovf = ovf_reg;
`else
    lockin_mac #(.DW(DW), .RW(RW), .ACCW(ACCW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .a       (mac_a),
        .b       (mac_b),
        .acc_in  (acc_cur),
        .acc_out (acc_sum)
    );
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = MAC;
            MAC:  if (last_step) state_next = window_done ? DUMP : IDLE;
            DUMP: if (out_ready && ch_reg == CHW'(NCH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DUMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_reg <= '0;
            samp_reg <= '0;
            sin_reg  <= '0;
            cos_reg  <= '0;
            len_reg  <= '0;
            cnt_reg  <= '0;
            ch_reg   <= '0;
            for (int k = 0; k < NACC; k++) acc_reg[k] <= '0;
            for (int c = 0; c < NCH; c++) begin
                buf_i[c] <= '0;
                buf_q[c] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        samp_reg <= in_sample;
                        sin_reg  <= ref_sin;
                        cos_reg  <= ref_cos;
                        step_reg <= '0;
                        if (cnt_reg == '0) begin
                            len_reg <= (dec_len == '0) ? DECW'(1) : dec_len;
                        end
                    end
                end
                MAC: begin
                    for (int k = 0; k < NACC; k++) begin
                        if (acc_en && step_reg == STW'(k + 1)) acc_reg[k] <= acc_sum;
                    end
                    if (last_step) begin
                        step_reg <= '0;
                        if (window_done) begin
                            cnt_reg <= '0;
                            ch_reg  <= '0;
                            for (int c = 0; c < NCH; c++) begin
                                buf_i[c] <= acc_reg[2*c];
                                buf_q[c] <= acc_reg[2*c+1];
                            end
                            for (int k = 0; k < NACC; k++) acc_reg[k] <= '0;
                        end else begin
                            cnt_reg <= cnt_inc[DECW-1:0];
                        end
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        ch_reg <= (ch_reg == CHW'(NCH - 1)) ? '0 : ch_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_ch = ch_reg;
    assign out_i  = buf_i[ch_reg];
    assign out_q  = buf_q[ch_reg];

endmodule
